// File: rtl/sys_array_sequencer.sv
// sys_array_sequencer: control FSM for one systolic array.
// Loads ARRAY_W weight rows, then feeds M input rows as a skewed wavefront
// across ARRAY_L lanes and strobes each result row as it leaves the array.
// All step activity advances on a divided tick (one tick per CLOCK_DIVIDE clks).
module sys_array_sequencer #(
    parameter int ARRAY_W      = 4,
    parameter int ARRAY_L      = 4,
    parameter int MAX_ROWS     = 16,
    parameter int CLOCK_DIVIDE = 2,
    localparam int PIPE = ARRAY_W + ARRAY_L - 1,
    localparam int RW   = $clog2(MAX_ROWS + 1),
    localparam int SW   = $clog2(MAX_ROWS + PIPE),
    localparam int WAW  = (ARRAY_W > 1) ? $clog2(ARRAY_W) : 1,
    localparam int RAW  = (MAX_ROWS > 1) ? $clog2(MAX_ROWS) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load_params,
    input  logic               start_comp,
    input  logic [RW-1:0]      num_rows,
    output logic               busy,
    output logic               done,
    output logic               err,
    output logic               w_load,
    output logic [WAW-1:0]     w_addr,
    output logic               sys_en,
    output logic [SW-1:0]      a_step,
    output logic [ARRAY_L-1:0] a_mask,
    output logic               r_valid,
    output logic [RAW-1:0]     r_addr
);

    // Compare width one bit wider than the step counter so sums never overflow.
    localparam int CW = SW + 1;
    localparam int DW = (CLOCK_DIVIDE > 1) ? $clog2(CLOCK_DIVIDE) : 1;

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_COMP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    logic [1:0]         state_reg;
    logic [DW-1:0]      div_reg;
    logic [SW-1:0]      step_reg;
    logic [RW-1:0]      m_reg;
    logic               params_loaded_reg;

    logic               tick;
    logic [CW-1:0]      s_ext;
    logic [CW-1:0]      m_ext;
    logic               load_last;
    logic               comp_last;
    logic               rows_ok;
    logic               r_hit;
    logic [ARRAY_L-1:0] mask_next;

    // Divider counter restarts on entry, so the first tick lands CLOCK_DIVIDE edges later.
    assign tick      = (div_reg == DW'(CLOCK_DIVIDE - 1));
    assign s_ext     = CW'(step_reg);
    assign m_ext     = CW'(m_reg);
    assign load_last = (s_ext == CW'(ARRAY_W - 1));
    assign comp_last = (s_ext == m_ext + CW'(PIPE - 1));
    assign rows_ok   = (num_rows != '0) && (CW'(num_rows) <= CW'(MAX_ROWS));
    assign r_hit     = (s_ext >= CW'(PIPE)) && (s_ext < m_ext + CW'(PIPE));

    // Lane gi is fed input row s-gi while that row exists.
    generate
        for (genvar gi = 0; gi < ARRAY_L; gi++) begin : g_mask
            assign mask_next[gi] = (s_ext >= CW'(gi)) && ((s_ext - CW'(gi)) < m_ext);
        end
    endgenerate

    // Sequencer state, divider, step counter and all registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg         <= S_IDLE;
            div_reg           <= '0;
            step_reg          <= '0;
            m_reg             <= '0;
            params_loaded_reg <= 1'b0;
            busy              <= 1'b0;
            done              <= 1'b0;
            err               <= 1'b0;
            w_load            <= 1'b0;
            w_addr            <= '0;
            sys_en            <= 1'b0;
            a_step            <= '0;
            a_mask            <= '0;
            r_valid           <= 1'b0;
            r_addr            <= '0;
        end else begin
            // busy follows the registered state, so it rises the cycle after accept
            // and stays high through the last LOAD tick and the DONE cycle.
            busy    <= (state_reg != S_IDLE);
            w_load  <= 1'b0;
            sys_en  <= 1'b0;
            r_valid <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
            a_mask  <= '0;
            case (state_reg)
                S_IDLE: begin
                    if (load_params) begin
                        state_reg         <= S_LOAD;
                        params_loaded_reg <= 1'b0;
                        div_reg           <= '0;
                        step_reg          <= '0;
                    end else if (start_comp) begin
                        if (params_loaded_reg && rows_ok) begin
                            state_reg <= S_COMP;
                            m_reg     <= num_rows;
                            div_reg   <= '0;
                            step_reg  <= '0;
                        end else begin
                            err <= 1'b1;
                        end
                    end
                end
                S_LOAD: begin
                    div_reg <= tick ? '0 : div_reg + DW'(1);
                    if (tick) begin
                        w_load <= 1'b1;
                        w_addr <= WAW'(step_reg);
                        if (load_last) begin
                            params_loaded_reg <= 1'b1;
                            state_reg         <= S_IDLE;
                        end else begin
                            step_reg <= step_reg + SW'(1);
                        end
                    end
                end
                S_COMP: begin
                    div_reg <= tick ? '0 : div_reg + DW'(1);
                    if (tick) begin
                        sys_en  <= 1'b1;
                        a_step  <= step_reg;
                        a_mask  <= mask_next;
                        r_valid <= r_hit;
                        if (r_hit) begin
                            r_addr <= RAW'(s_ext - CW'(PIPE));
                        end
                        if (comp_last) begin
                            state_reg <= S_DONE;
                        end else begin
                            step_reg <= step_reg + SW'(1);
                        end
                    end
                end
                S_DONE: begin
                    done      <= 1'b1;
                    state_reg <= S_IDLE;
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/sys_array_sequencer.md
Name: sys_array_sequencer

Overview:
- Control FSM that sequences one systolic array: weight load, skewed input feed, result drain.
- Sits between the host control pulses (load_params, start_comp) and the array datapath plus its operand/result buffers.
- Generates buffer addresses, the per-lane skew mask, array step enables and result write strobes.
- Steps advance on a divided tick so the array runs at clk/CLOCK_DIVIDE.

Parameters:
- ARRAY_W, 4, array rows = number of weight rows loaded.
- ARRAY_L, 4, array lanes (columns) fed with skewed input.
- MAX_ROWS, 16, maximum input rows M per computation.
- CLOCK_DIVIDE, 2, clk cycles per step tick; must be >=1.
- Derived: PIPE = ARRAY_W+ARRAY_L-1; RW = $clog2(MAX_ROWS+1); SW = $clog2(MAX_ROWS+PIPE).

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- load_params  in  1  pulse; request weight load.
- start_comp  in  1  pulse; request computation.
- num_rows  in  RW  input row count M; sampled when start_comp is accepted.
- busy  out  1  high in LOAD, COMP and DONE.
- done  out  1  one-cycle pulse at end of COMP.
- err  out  1  one-cycle pulse when a request is rejected.
- w_load  out  1  weight shift enable, one cycle per tick in LOAD.
- w_addr  out  $clog2(ARRAY_W)  weight row address, valid with w_load.
- sys_en  out  1  array step enable, one cycle per tick in COMP.
- a_step  out  SW  current wavefront index s, valid with sys_en.
- a_mask  out  ARRAY_L  lane k valid (reads input row s-k).
- r_valid  out  1  result row write strobe.
- r_addr  out  $clog2(MAX_ROWS)  result row index, valid with r_valid.

Behaviour:
- Reset (async, any state): state=IDLE; all outputs 0; divider, step counter, latched M and params_loaded cleared.
- All outputs are registered.
- Divider: counter cleared on entry to LOAD/COMP. A tick occurs every CLOCK_DIVIDE cycles. The n-th tick (n=1,2,...) after the accept edge E0 is visible in cycle E0+n*CLOCK_DIVIDE. Non-tick cycles: w_load=sys_en=r_valid=0.
- IDLE, request accept rules:
  - load_params=1 -> LOAD. load_params wins if both requests are high.
  - start_comp=1, params_loaded=1, 1<=num_rows<=MAX_ROWS -> latch M, go to COMP.
  - start_comp=1 without params_loaded, or num_rows==0, or num_rows>MAX_ROWS -> err pulse next cycle; stay IDLE.
- Requests outside IDLE are ignored: no err, no queuing.
- LOAD: ticks 1..ARRAY_W drive w_load=1, w_addr=tick-1. After the last tick: params_loaded=1, state -> IDLE next cycle.
- A new LOAD clears params_loaded at entry and re-sets it at completion.
- COMP: step s runs 0..M+PIPE-1, one step per tick. Per step:
  - sys_en=1, a_step=s.
  - a_mask[k] = (s>=k) && (s-k<M).
  - r_valid = (PIPE<=s<PIPE+M); r_addr = s-PIPE.
  - After step M+PIPE-1 -> DONE.
- DONE: done=1 for exactly one cycle, busy=1, then IDLE. params_loaded is retained for repeated computations.
- busy: asserted from the cycle after the accept edge through the DONE cycle (LOAD: through its last tick cycle).
- Step counter never wraps: its max value M+PIPE-1 fits in SW.
- Reset mid-LOAD/COMP: immediate return to IDLE with outputs 0. No done. params_loaded cleared.

Test Plan:
1. Reset, then load_params pulse (defaults) -> w_load high in cycles E0+2,4,6,8 with w_addr 0,1,2,3; busy high 8 cycles; then IDLE.
2. After load, start_comp with num_rows=3 -> 10 sys_en pulses, every 2nd cycle.
   - a_mask: s0=0001, s2=0111, s3=1110, s5=1000, s6=0000.
   - r_valid at s=7,8,9 with r_addr 0,1,2.
   - done one cycle after the 10th tick; a second start_comp is accepted without reload.
3. start_comp right after reset (no load) -> err single-cycle pulse; busy, sys_en stay 0.
4. num_rows=0, and separately num_rows=17 -> err pulse, no COMP. load_params+start_comp same cycle -> LOAD only.
5. Reset asserted at COMP step 4 -> all outputs 0 immediately. Subsequent start_comp -> err (params cleared).
6. CLOCK_DIVIDE=1, num_rows=1 -> 8 consecutive sys_en cycles; r_valid only at s=7, r_addr 0; done the next cycle; mid-COMP load_params/start_comp ignored.
